// File: rtl/axis_ram_pkg.sv
// Shared constants, types and helpers for the AXI RAM reader.
package axis_ram_pkg;

   localparam int unsigned BURST_LEN = 16;
   localparam logic [1:0]  INCR      = 2'b01;
   localparam logic [3:0]  CACHE     = 4'b1111;

   typedef enum logic {
      AR_IDLE,
      AR_REQ
   } ar_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; dout shows the head word while not empty.
module sync_fifo_fwft
   import axis_ram_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 512
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [WIDTH-1:0]      din,
   input  logic                  wr_en,
   output logic [WIDTH-1:0]      dout,
   input  logic                  rd_en,
   output logic                  empty,
   output logic                  full,
   output logic [clog2(DEPTH):0] count
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = wr_en & ~full;
   assign rd_ok = rd_en & ~empty;
   assign empty = (count == '0);
   assign full  = count[AW];
   assign dout  = mem[rd_ptr];

   // Storage array, written at the tail; no reset needed on data.
   always_ff @(posedge aclk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; simultaneous read and write leave count unchanged.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis_ram_reader.sv
// Plays a circular DDR buffer out as an AXI4-Stream using credit-limited 16-beat AXI3 reads.
module axis_ram_reader
   import axis_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = 20,
   parameter int unsigned AXI_ID_WIDTH     = 6,
   parameter int unsigned AXI_ADDR_WIDTH   = 32,
   parameter int unsigned AXI_DATA_WIDTH   = 64,
   parameter int unsigned AXIS_TDATA_WIDTH = 64,
   parameter int unsigned FIFO_DEPTH       = 512,
   parameter int unsigned MAX_OUTSTANDING  = 4
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]   cfg_data,
   output logic [ADDR_WIDTH-1:0]       sts_data,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [3:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   output logic [3:0]                  m_axi_arcache,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic                        m_axi_rlast,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready
);

   localparam int unsigned ARSIZE = clog2(AXI_DATA_WIDTH / 8);
   localparam int unsigned CNT_W  = clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OUT_W  = clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned RES_W  = clog2(FIFO_DEPTH + BURST_LEN * (MAX_OUTSTANDING + 1)) + 1;

   ar_state_t               ar_state;
   ar_state_t               ar_state_nxt;
   logic [ADDR_WIDTH-1:0]   burst_addr;
   logic [AXI_ID_WIDTH-1:0] arid_q;
   logic [OUT_W-1:0]        outstanding;
   logic [ADDR_WIDTH-1:0]   sts_q;
   logic                    rready_q;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_wr;
   logic                    fifo_rd;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic [RES_W-1:0]        reserved;
   logic                    credit_ok;
   logic                    ar_hs;
   logic                    r_last_hs;
   logic                    unused_rid;

   assign unused_rid = ^m_axi_rid;

   if (AXI_DATA_WIDTH > AXIS_TDATA_WIDTH) begin : g_rdata_msb
      logic unused_rdata_msb;
      assign unused_rdata_msb = ^m_axi_rdata[AXI_DATA_WIDTH-1:AXIS_TDATA_WIDTH];
   end

   assign m_axi_arid    = arid_q;
   assign m_axi_araddr  = cfg_data + (AXI_ADDR_WIDTH'(burst_addr) << ARSIZE);
   assign m_axi_arlen   = 4'(BURST_LEN - 1);
   assign m_axi_arsize  = 3'(ARSIZE);
   assign m_axi_arburst = INCR;
   assign m_axi_arcache = CACHE;
   assign m_axi_rready  = rready_q;
   assign sts_data      = sts_q;
   assign m_axis_tvalid = ~fifo_empty;

   assign ar_hs     = m_axi_arvalid & m_axi_arready;
   assign r_last_hs = m_axi_rvalid & rready_q & m_axi_rlast;
   assign fifo_wr   = m_axi_rvalid & rready_q;
   assign fifo_rd   = m_axis_tvalid & m_axis_tready;

   // Beats of a partly returned burst count both in the FIFO and in outstanding,
   // so the reservation is conservative and the FIFO can never overflow.
   assign reserved  = RES_W'(fifo_count) + RES_W'(outstanding) * RES_W'(BURST_LEN);
   assign credit_ok = ((reserved + RES_W'(BURST_LEN)) <= RES_W'(FIFO_DEPTH)) &&
                      (outstanding < OUT_W'(MAX_OUTSTANDING));

   // AR request state register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ar_state <= AR_IDLE;
      end else begin
         ar_state <= ar_state_nxt;
      end
   end

   // Raise arvalid once credit is available and hold it until accepted.
   always_comb begin
      ar_state_nxt  = ar_state;
      m_axi_arvalid = 1'b0;
      case (ar_state)
         AR_IDLE: begin
            if (credit_ok) begin
               ar_state_nxt = AR_REQ;
            end
         end
         AR_REQ: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) begin
               ar_state_nxt = AR_IDLE;
            end
         end
         default: ar_state_nxt = AR_IDLE;
      endcase
   end

   // Burst address, ID and in-flight burst counters.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         burst_addr  <= '0;
         arid_q      <= '0;
         outstanding <= '0;
      end else begin
         if (ar_hs) begin
            burst_addr <= burst_addr + ADDR_WIDTH'(BURST_LEN);
            arid_q     <= arid_q + AXI_ID_WIDTH'(1);
         end
         case ({ar_hs, r_last_hs})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Delivered-word count and R-channel ready.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         sts_q    <= '0;
         rready_q <= 1'b0;
      end else begin
         rready_q <= 1'b1;
         if (fifo_rd) begin
            sts_q <= sts_q + ADDR_WIDTH'(1);
         end
      end
   end

   // A beat arriving at a full FIFO means the credit accounting is broken.
   assert property (@(posedge aclk) disable iff (!aresetn) !(fifo_wr && fifo_full));

   sync_fifo_fwft #(
      .WIDTH (AXIS_TDATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .din     (m_axi_rdata[AXIS_TDATA_WIDTH-1:0]),
      .wr_en   (fifo_wr),
      .dout    (m_axis_tdata),
      .rd_en   (fifo_rd),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_axis_ram_reader.sv
// Self-checking bench for axis_ram_reader with an AXI3 read-slave model and a stream scoreboard.
`timescale 1ns/1ps
module tb_axis_ram_reader;

   localparam int AW        = 6;
   localparam int BUF_WORDS = 1 << AW;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [31:0]   cfg_data;
   logic [AW-1:0] sts_data;
   logic [5:0]    m_axi_arid;
   logic [31:0]   m_axi_araddr;
   logic [3:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic [3:0]    m_axi_arcache;
   logic          m_axi_arvalid;
   logic          m_axi_arready;
   logic [5:0]    m_axi_rid;
   logic [63:0]   m_axi_rdata;
   logic          m_axi_rlast;
   logic          m_axi_rvalid;
   logic          m_axi_rready;
   logic [63:0]   m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;

   always #5 aclk = ~aclk;

   axis_ram_reader #(
      .ADDR_WIDTH       (AW),
      .AXI_ID_WIDTH     (6),
      .AXI_ADDR_WIDTH   (32),
      .AXI_DATA_WIDTH   (64),
      .AXIS_TDATA_WIDTH (64),
      .FIFO_DEPTH       (512),
      .MAX_OUTSTANDING  (4)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .cfg_data      (cfg_data),
      .sts_data      (sts_data),
      .m_axi_arid    (m_axi_arid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rid     (m_axi_rid),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   // ---------------- bench state ----------------
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int ar_count = 0, rlast_count = 0, rx_beats = 0, words_out = 0;
   int peak_out = 0, out_viol = 0, rlast_at5 = -1;
   int ar_limit = -1, arready_pct = 100, tready_pct = 100, rgap_pct = 0, r_latency = 1;
   int stop_at = 32'h7fff_ffff;
   bit hold_mode = 0, idx_mode = 0;
   int hold_cnt = 0, beat = 0, out_now = 0;
   logic [31:0] cap_addr;
   logic [5:0]  cap_id;
   bit          prev_stall = 0;
   logic [63:0] prev_tdata;

   typedef struct {
      logic [31:0] addr;
      logic [5:0]  id;
      int          t;
   } burst_t;
   burst_t      arq[$];
   logic [31:0] ar_addr_log[$];
   logic [5:0]  ar_id_log[$];

   typedef struct {
      logic [31:0] cfg;
      int          tready_pct;
      int          rgap_pct;
      int          arready_pct;
      int          latency;
      int          nwords;
      int          exp_sts;
   } scen_t;
   scen_t scen[4];

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory contents: a distinct pattern per byte address.
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hA5C3_0F1E, ~a};
   endfunction

   // Word k of the stream comes from buffer slot k mod 2^AW.
   function automatic logic [63:0] exp_word(input int k);
      logic [31:0] a;
      a = cfg_data + 32'((k % BUF_WORDS) * 8);
      return idx_mode ? 64'(k % BUF_WORDS) : mem_word(a);
   endfunction

   function automatic logic [31:0] log_addr(input int i);
      return (i < ar_addr_log.size()) ? ar_addr_log[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [5:0] log_id(input int i);
      return (i < ar_id_log.size()) ? ar_id_log[i] : 6'hxx;
   endfunction

   // ---------------- AR slave ----------------
   initial begin
      m_axi_arready = 1'b0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            m_axi_arready = 1'b0;
            hold_cnt = 0;
         end else begin
            if (ar_limit >= 0 && ar_count >= ar_limit) begin
               m_axi_arready = 1'b0;
            end else if (hold_mode) begin
               if (hold_cnt > 0) begin
                  chk("hold_arvalid", 64'(m_axi_arvalid), 64'(1));
                  chk("hold_araddr", 64'(m_axi_araddr), 64'(cap_addr));
                  chk("hold_arid", 64'(m_axi_arid), 64'(cap_id));
               end
               if (m_axi_arvalid || hold_cnt > 0) begin
                  if (hold_cnt == 0) begin
                     cap_addr = m_axi_araddr;
                     cap_id   = m_axi_arid;
                  end
                  if (hold_cnt < 10) begin
                     m_axi_arready = 1'b0;
                     hold_cnt++;
                  end else begin
                     m_axi_arready = 1'b1;
                  end
               end else begin
                  m_axi_arready = 1'b0;
               end
            end else begin
               m_axi_arready = (int'($urandom_range(99)) < arready_pct);
            end
            if (m_axi_arvalid && m_axi_arready) begin
               arq.push_back('{addr: m_axi_araddr, id: m_axi_arid, t: cyc});
               ar_addr_log.push_back(m_axi_araddr);
               ar_id_log.push_back(m_axi_arid);
               ar_count++;
               if (ar_count == 5) rlast_at5 = rlast_count;
               chk("arlen", 64'(m_axi_arlen), 64'(15));
               chk("arsize", 64'(m_axi_arsize), 64'(3));
               chk("arburst", 64'(m_axi_arburst), 64'(1));
               chk("arcache", 64'(m_axi_arcache), 64'(15));
               hold_cnt = 0;
            end
         end
      end
   end

   // ---------------- R slave ----------------
   initial begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rid    = '0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            beat = 0;
         end else begin
            if (arq.size() > 0 && cyc >= arq[0].t + r_latency &&
                int'($urandom_range(99)) >= rgap_pct) begin
               logic [31:0] a;
               a = arq[0].addr + 32'(beat * 8);
               m_axi_rvalid = 1'b1;
               m_axi_rid    = arq[0].id;
               m_axi_rdata  = idx_mode ? 64'((a - cfg_data) >> 3) : mem_word(a);
               m_axi_rlast  = (beat == 15);
            end else begin
               m_axi_rvalid = 1'b0;
               m_axi_rlast  = 1'b0;
            end
            if (m_axi_rvalid && m_axi_rready) begin
               rx_beats++;
               if (beat == 15) begin
                  beat = 0;
                  void'(arq.pop_front());
                  rlast_count++;
               end else begin
                  beat++;
               end
            end
         end
      end
   end

   // ---------------- in-flight burst monitor ----------------
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (aresetn) begin
            out_now = ar_count - rlast_count;
            if (out_now > peak_out) peak_out = out_now;
            if (out_now > 4) out_viol++;
         end
      end
   end

   // ---------------- stream sink and scoreboard ----------------
   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            m_axis_tready = 1'b0;
            prev_stall = 0;
         end else begin
            chk("sts_data", 64'(sts_data), 64'(words_out % BUF_WORDS));
            if (prev_stall) begin
               chk("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
               chk("stall_tdata", m_axis_tdata, prev_tdata);
            end
            m_axis_tready = (words_out < stop_at) && (int'($urandom_range(99)) < tready_pct);
            if (m_axis_tvalid && m_axis_tready) begin
               chk("tdata", m_axis_tdata, exp_word(words_out));
               words_out++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_tdata = m_axis_tdata;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      arq.delete();
      ar_addr_log.delete();
      ar_id_log.delete();
      ar_count = 0; rlast_count = 0; rx_beats = 0; words_out = 0;
      peak_out = 0; out_viol = 0; rlast_at5 = -1; beat = 0; hold_cnt = 0;
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("rst_sts", 64'(sts_data), 64'(0));
      chk("rst_rready", 64'(m_axi_rready), 64'(0));
      aresetn = 1'b1;
   endtask

   task automatic wait_words(input int n, input int budget, input string name);
      int i;
      i = 0;
      while (words_out < n && i < budget) begin
         @(negedge aclk);
         i++;
      end
      chk({name, "_timeout"}, 64'(words_out >= n), 64'(1));
   endtask

   task automatic set_mode(input logic [31:0] cfg, input int trp, input int rgp,
                           input int arp, input int lat);
      cfg_data = cfg; tready_pct = trp; rgap_pct = rgp; arready_pct = arp; r_latency = lat;
   endtask

   // Hard stop if something wedges beyond every per-wait budget.
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int i;
      logic [31:0] wrap_off[5];

      scen[0] = '{32'h3000_0000, 50, 30, 70, 3, 10000, 16};
      scen[1] = '{32'h0000_0400, 100, 0, 100, 1, 600, 24};
      scen[2] = '{32'h7FFF_FE00, 25, 60, 40, 12, 1500, 28};
      scen[3] = '{32'hC000_0080, 90, 10, 90, 25, 1500, 28};
      wrap_off = '{32'd0, 32'd128, 32'd256, 32'd384, 32'd0};

      // Single burst, data equals word index.
      idx_mode = 1; ar_limit = 1;
      set_mode(32'h1000_0000, 100, 0, 100, 2);
      do_reset();
      wait_words(16, 300, "single");
      repeat (20) @(negedge aclk);
      chk("single_ar_count", 64'(ar_count), 64'(1));
      chk("single_araddr", 64'(log_addr(0)), 64'(32'h1000_0000));
      chk("single_words", 64'(words_out), 64'(16));
      chk("single_sts", 64'(sts_data), 64'(16));
      idx_mode = 0; ar_limit = -1;

      // Stream held off: credit stops issue at exactly a full FIFO.
      set_mode(32'h1000_0000, 0, 0, 100, 2);
      do_reset();
      repeat (1500) @(negedge aclk);
      chk("full_ar_count", 64'(ar_count), 64'(32));
      chk("full_rx_beats", 64'(rx_beats), 64'(512));
      chk("full_arvalid", 64'(m_axi_arvalid), 64'(0));
      tready_pct = 100;
      wait_words(600, 3000, "full_drain");

      // Long read latency: outstanding capped at 4.
      set_mode(32'h1000_0000, 100, 0, 100, 40);
      do_reset();
      wait_words(200, 2000, "latency");
      chk("peak_outstanding", 64'(peak_out), 64'(4));
      chk("outstanding_violations", 64'(out_viol), 64'(0));
      chk("fifth_ar_after_rlast", 64'(rlast_at5 >= 1), 64'(1));

      // Address wrap and sts_data wrap.
      set_mode(32'h2000_0000, 100, 0, 100, 2);
      stop_at = 64;
      do_reset();
      wait_words(64, 1000, "wrap");
      repeat (3) @(negedge aclk);
      chk("wrap_sts", 64'(sts_data), 64'(0));
      chk("wrap_words", 64'(words_out), 64'(64));
      stop_at = 32'h7fff_ffff;
      wait_words(70, 500, "wrap_more");
      for (int k = 0; k < 5; k++) begin
         chk("wrap_araddr", 64'(log_addr(k)), 64'(32'h2000_0000 + wrap_off[k]));
      end

      // arready held low for 10 cycles per request.
      hold_mode = 1;
      set_mode(32'h4000_0000, 100, 0, 100, 2);
      do_reset();
      i = 0;
      while (ar_count < 3 && i < 300) begin
         @(negedge aclk);
         i++;
      end
      chk("hold_timeout", 64'(ar_count >= 3), 64'(1));
      for (int k = 0; k < 3; k++) begin
         chk("hold_arid_seq", 64'(log_id(k)), 64'(k));
      end
      hold_mode = 0;

      // Randomised scenarios against the buffer model.
      for (int s = 0; s < 4; s++) begin
         set_mode(scen[s].cfg, scen[s].tready_pct, scen[s].rgap_pct,
                  scen[s].arready_pct, scen[s].latency);
         stop_at = scen[s].nwords;
         do_reset();
         wait_words(scen[s].nwords, scen[s].nwords * 8 + 500, "rand");
         repeat (5) @(negedge aclk);
         chk("rand_words", 64'(words_out), 64'(scen[s].nwords));
         chk("rand_sts", 64'(sts_data), 64'(scen[s].exp_sts));
      end
      stop_at = 32'h7fff_ffff;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
